// File: rtl/stopwatch_bcd_counter_pkg.sv
// Shared definitions for the stopwatch core and the display selector.
// Holds the one-hot state encodings, the BCD digit limits and the o_data field positions.
// Any block that slices the 24-bit time word should take its field positions from here.
package stopwatch_bcd_counter_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_RUN   = 4'b0010,
        ST_PAUSE = 4'b0100,
        ST_FULL  = 4'b1000
    } state_t;

    // One-hot bit positions, so status outputs come straight off a single flop
    localparam int ST_RUN_BIT  = 1;
    localparam int ST_FULL_BIT = 3;

    localparam int BCD_MAX_9 = 9;
    localparam int BCD_MAX_5 = 5;

    // LSB positions of each 4-bit digit inside o_data
    localparam int FLD_W        = 4;
    localparam int FLD_CS_ONES  = 0;
    localparam int FLD_CS_TENS  = 4;
    localparam int FLD_SEC_ONES = 8;
    localparam int FLD_SEC_TENS = 12;
    localparam int FLD_MIN_ONES = 16;
    localparam int FLD_MIN_TENS = 20;

endpackage

// File: rtl/stopwatch_bcd_counter_bcd_digit_cnt.sv
// One BCD digit of the stopwatch, counting 0..MAX and wrapping to 0 when it carries.
// Latency: the digit updates on the edge where i_inc is high; o_carry is combinational.
// No backpressure: i_inc is accepted on every cycle it is high.
module bcd_digit_cnt
    import stopwatch_bcd_counter_pkg::*;
#(
    parameter int MAX = BCD_MAX_9
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_clr,
    input  logic       i_inc,
    output logic [3:0] o_digit,
    output logic       o_carry
);

    localparam logic [3:0] MAX_D = 4'(MAX);

    logic [3:0] digit;
    logic       at_max;

    // Treat anything at or above MAX as the wrap point so the digit can never leave its legal range
    assign at_max = (digit >= MAX_D);

    // Digit register: clear beats increment
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            digit <= 4'd0;
        end else if (i_clr) begin
            digit <= 4'd0;
        end else if (i_inc) begin
            digit <= at_max ? 4'd0 : digit + 4'd1;
        end
    end

    assign o_digit = digit;
    assign o_carry = i_inc & at_max;

endmodule

// File: rtl/stopwatch_bcd_counter.sv
// BCD stopwatch core: mm:ss.cc counted from the system clock, start/stop toggle and clear buttons.
// Latency: buttons act on the edge they are sampled; first increment lands CLK_DIV edges after start.
// No backpressure: button pulses are consumed every cycle; a held level toggles every cycle.
module stopwatch_bcd_counter
    import stopwatch_bcd_counter_pkg::*;
#(
    parameter int CLK_DIV = 500000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_btn_start,
    input  logic        i_btn_clear,
    output logic [23:0] o_data,
    output logic        o_running,
    output logic        o_full
);

    localparam int             PW     = $clog2(CLK_DIV);
    localparam logic [PW-1:0]  P_LAST = PW'(CLK_DIV - 1);

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] presc;
    logic          tick;
    logic          time_full;
    logic          inc_cs;
    logic          min_tens_carry;

    logic [3:0] cs_ones, cs_tens, sec_ones, sec_tens, min_ones, min_tens;
    logic       c_cs_ones, c_cs_tens, c_sec_ones, c_sec_tens, c_min_ones;

    assign tick      = (state == ST_RUN) && (presc == P_LAST);
    assign time_full = (cs_ones  == 4'(BCD_MAX_9)) && (cs_tens  == 4'(BCD_MAX_9)) &&
                       (sec_ones == 4'(BCD_MAX_9)) && (sec_tens == 4'(BCD_MAX_5)) &&
                       (min_ones == 4'(BCD_MAX_9)) && (min_tens == 4'(BCD_MAX_5));
    // At 59:59.99 the tick moves the FSM to FULL instead of rolling the time over
    assign inc_cs    = tick & ~time_full;

    // Prescaler: runs only in RUN, so a pause keeps the partial tick for the resume
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            presc <= '0;
        end else if (i_btn_clear) begin
            presc <= '0;
        end else if ((state == ST_IDLE) && i_btn_start) begin
            presc <= '0;
        end else if (state == ST_RUN) begin
            presc <= tick ? '0 : presc + 1'b1;
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: clear wins everywhere; saturation beats a coincident stop
    always_comb begin
        state_nxt = state;
        if (i_btn_clear) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (i_btn_start) state_nxt = ST_RUN;
                ST_RUN: begin
                    // min_tens_carry only rises if 59:59.99 ever escaped the gating; saturate then too
                    if (tick && (time_full || min_tens_carry)) state_nxt = ST_FULL;
                    else if (i_btn_start)                      state_nxt = ST_PAUSE;
                end
                ST_PAUSE: if (i_btn_start) state_nxt = ST_RUN;
                ST_FULL:  state_nxt = ST_FULL;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // Status outputs taken from single one-hot state flops
    always_comb begin
        o_running = state[ST_RUN_BIT];
        o_full    = state[ST_FULL_BIT];
    end

    bcd_digit_cnt #(.MAX(BCD_MAX_9)) u_cs_ones (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(i_btn_clear),
        .i_inc(inc_cs), .o_digit(cs_ones), .o_carry(c_cs_ones)
    );
    bcd_digit_cnt #(.MAX(BCD_MAX_9)) u_cs_tens (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(i_btn_clear),
        .i_inc(c_cs_ones), .o_digit(cs_tens), .o_carry(c_cs_tens)
    );
    bcd_digit_cnt #(.MAX(BCD_MAX_9)) u_sec_ones (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(i_btn_clear),
        .i_inc(c_cs_tens), .o_digit(sec_ones), .o_carry(c_sec_ones)
    );
    bcd_digit_cnt #(.MAX(BCD_MAX_5)) u_sec_tens (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(i_btn_clear),
        .i_inc(c_sec_ones), .o_digit(sec_tens), .o_carry(c_sec_tens)
    );
    bcd_digit_cnt #(.MAX(BCD_MAX_9)) u_min_ones (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(i_btn_clear),
        .i_inc(c_sec_tens), .o_digit(min_ones), .o_carry(c_min_ones)
    );
    bcd_digit_cnt #(.MAX(BCD_MAX_5)) u_min_tens (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(i_btn_clear),
        .i_inc(c_min_ones), .o_digit(min_tens), .o_carry(min_tens_carry)
    );

    // Time word is a direct view of the digit flops
    always_comb begin
        o_data                             = '0;
        o_data[FLD_CS_ONES  +: FLD_W]      = cs_ones;
        o_data[FLD_CS_TENS  +: FLD_W]      = cs_tens;
        o_data[FLD_SEC_ONES +: FLD_W]      = sec_ones;
        o_data[FLD_SEC_TENS +: FLD_W]      = sec_tens;
        o_data[FLD_MIN_ONES +: FLD_W]      = min_ones;
        o_data[FLD_MIN_TENS +: FLD_W]      = min_tens;
    end

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Directed bench for stopwatch_bcd_counter with CLK_DIV = 4.
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
// Long counts are shortened by preloading the digit registers while paused.
module tb_stopwatch_bcd_counter;

    localparam int CLK_DIV = 4;

    logic        clk;
    logic        rst_n;
    logic        btn_start;
    logic        btn_clear;
    logic [23:0] data;
    logic        running;
    logic        full;

    int n_cmp = 0;
    int n_err = 0;

    stopwatch_bcd_counter #(.CLK_DIV(CLK_DIV)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_btn_start(btn_start),
        .i_btn_clear(btn_clear),
        .o_data     (data),
        .o_running  (running),
        .o_full     (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        btn_start = 1'b1;
        step(1);
        btn_start = 1'b0;
    endtask

    task automatic pulse_clear();
        btn_clear = 1'b1;
        step(1);
        btn_clear = 1'b0;
    endtask

    // Load a BCD time into the digit registers over one edge (used only while paused)
    task automatic preload(input logic [23:0] v);
        force dut.u_cs_ones.digit  = v[3:0];
        force dut.u_cs_tens.digit  = v[7:4];
        force dut.u_sec_ones.digit = v[11:8];
        force dut.u_sec_tens.digit = v[15:12];
        force dut.u_min_ones.digit = v[19:16];
        force dut.u_min_tens.digit = v[23:20];
        step(1);
        release dut.u_cs_ones.digit;
        release dut.u_cs_tens.digit;
        release dut.u_sec_ones.digit;
        release dut.u_sec_tens.digit;
        release dut.u_min_ones.digit;
        release dut.u_min_tens.digit;
    endtask

    initial begin
        rst_n     = 1'b0;
        btn_start = 1'b0;
        btn_clear = 1'b0;

        // 1. reset with buttons idle
        step(3);
        chk("rst_hold_data", data, 24'h000000);
        rst_n = 1'b1;
        step(1);
        chk("rst_data", data, 24'h000000);
        chk("rst_running", {23'd0, running}, 24'd0);
        chk("rst_full", {23'd0, full}, 24'd0);

        // 2. basic count: first increment exactly 4 edges after start
        pulse_start();
        chk("start_running", {23'd0, running}, 24'd1);
        chk("start_data", data, 24'h000000);
        step(3);
        chk("pre_first_inc", data, 24'h000000);
        step(1);
        chk("first_inc", data, 24'h000001);
        step(36);
        chk("run40", data, 24'h000010);
        pulse_clear();
        chk("clear_data", data, 24'h000000);
        chk("clear_running", {23'd0, running}, 24'd0);

        // 3. pause and resume keep the partial prescaler count
        pulse_start();
        step(5);
        pulse_start();
        chk("pause_data", data, 24'h000001);
        chk("pause_running", {23'd0, running}, 24'd0);
        step(20);
        chk("pause_hold", data, 24'h000001);
        pulse_start();
        chk("resume_running", {23'd0, running}, 24'd1);
        step(1);
        chk("resume_pre", data, 24'h000001);
        step(1);
        chk("resume_inc", data, 24'h000002);

        // 4a. carry out of seconds into minutes
        pulse_clear();
        pulse_start();
        step(CLK_DIV * 5999);
        chk("to_005999", data, 24'h005999);
        step(CLK_DIV);
        chk("carry_010000", data, 24'h010000);

        // 4b. carry into minute tens (pause leaves prescaler at 1)
        pulse_start();
        chk("pause_4b", {23'd0, running}, 24'd0);
        preload(24'h095999);
        chk("preload_095999", data, 24'h095999);
        pulse_start();
        step(2);
        chk("pre_carry_100000", data, 24'h095999);
        step(1);
        chk("carry_100000", data, 24'h100000);

        // 5. saturation at 59:59.99
        pulse_start();
        preload(24'h595999);
        chk("preload_595999", data, 24'h595999);
        pulse_start();
        step(3);
        chk("full_flag", {23'd0, full}, 24'd1);
        chk("full_data", data, 24'h595999);
        chk("full_running", {23'd0, running}, 24'd0);
        pulse_start();
        step(10);
        chk("full_start_ign", {23'd0, full}, 24'd1);
        chk("full_start_data", data, 24'h595999);
        chk("full_start_run", {23'd0, running}, 24'd0);
        pulse_clear();
        chk("full_clr_data", data, 24'h000000);
        chk("full_clr_full", {23'd0, full}, 24'd0);
        pulse_start();
        chk("full_clr_idle", {23'd0, running}, 24'd1);

        // 6a. start and clear together while running at 000123
        step(CLK_DIV * 123);
        chk("at_000123", data, 24'h000123);
        btn_start = 1'b1;
        btn_clear = 1'b1;
        step(1);
        btn_start = 1'b0;
        btn_clear = 1'b0;
        chk("both_data", data, 24'h000000);
        chk("both_running", {23'd0, running}, 24'd0);
        step(8);
        chk("both_idle_hold", data, 24'h000000);

        // 6b. reset in the middle of a count
        pulse_start();
        step(5);
        chk("pre_rst_data", data, 24'h000001);
        rst_n = 1'b0;
        step(1);
        chk("midrst_data", data, 24'h000000);
        chk("midrst_running", {23'd0, running}, 24'd0);
        chk("midrst_full", {23'd0, full}, 24'd0);
        rst_n = 1'b1;
        step(8);
        chk("post_rst_idle", data, 24'h000000);

        // held start toggles every cycle: IDLE->RUN->PAUSE->RUN, prescaler at 1
        btn_start = 1'b1;
        step(3);
        btn_start = 1'b0;
        chk("held_running", {23'd0, running}, 24'd1);
        step(2);
        chk("held_pre", data, 24'h000000);
        step(1);
        chk("held_inc", data, 24'h000001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stopwatch_bcd_counter.md
# stopwatch_bcd_counter

- BCD stopwatch core for the light_timer design. Sits directly upstream of the display/LED selector.
- Counts minutes, seconds and centiseconds from the system clock, controlled by start/stop and clear button pulses.
- Presents the time as a 24-bit packed BCD word on `o_data`; the selector consumes `o_data` as its `i_data`.
- Bits [7:4] and [4] of `o_data` drive the downstream blink logic, so they must be glitch-free registered outputs.

## Interface
- `CLK_DIV`, default 500000: system clock cycles per centisecond tick (50 MHz → 100 Hz). Legal range ≥ 2.
- `i_clk`  input  1: system clock; all logic on rising edge.
- `i_rst_n`  input  1: reset, synchronous, active-low.
- `i_btn_start`  input  1: single-cycle pulse from the debouncer; start/stop toggle.
- `i_btn_clear`  input  1: single-cycle pulse from the debouncer; clear to zero.
- `o_data`  output  24: packed BCD, [23:20] min tens, [19:16] min ones, [15:12] sec tens, [11:8] sec ones, [7:4] cs tens, [3:0] cs ones.
- `o_running`  output  1: high while in RUN.
- `o_full`  output  1: high while in FULL (count saturated at 59:59.99).

## Operation
States: IDLE, RUN, PAUSE, FULL (one-hot, 4 bits).

Transitions (clear has priority over start in every state):
- Any state, `i_btn_clear` = 1 → IDLE. Zero the time, zero the prescaler.
- IDLE, start → RUN. Zero the prescaler.
- RUN, start → PAUSE. Hold the time and the prescaler value.
- PAUSE, start → RUN. Resume from the held prescaler value; no partial-tick loss.
- RUN, tick while time = 59:59.99 → FULL. Time stays 59:59.99.
- FULL, start → ignored. Only clear exits FULL.

Prescaler:
- Counts 0..CLK_DIV-1, and only in RUN.
- The tick is asserted on the cycle where prescaler = CLK_DIV-1; the prescaler wraps to 0 on the same edge.

Increment on tick (ripple carry, all digits update on the same edge):
- cs ones 0..9, carry into cs tens 0..9.
- Carry into sec ones 0..9, then sec tens 0..5.
- Carry into min ones 0..9, then min tens 0..5.
- Each digit wraps to 0 when it carries.

Digit legality:
- Every digit stays a legal BCD value at all times.
- Tens digits for seconds and minutes never exceed 5.

Reset, `i_rst_n` = 0 at a clock edge:
- State → IDLE.
- `o_data` = 24'h000000, `o_running` = 0, `o_full` = 0, prescaler = 0.
- Reset takes priority over both buttons, including mid-count.

## Timing
- All outputs are registered; no combinational path from the inputs to the outputs.
- A start pulse at edge N:
  - `o_running` goes high after edge N.
  - The first increment is visible after edge N+CLK_DIV.
  - Each later increment follows CLK_DIV cycles after the previous one.
- A stop pulse at edge N freezes `o_data` after edge N. If edge N also carries a tick, that increment is kept.
- A clear pulse at edge N makes `o_data` zero after edge N.
- Start and clear in the same cycle: clear wins, and the result is IDLE, not RUN.
- On the tick from 59:59.99, `o_full` and the state change register on the same edge; `o_data` does not change.
- Buttons are single-cycle. A held high level is treated as a pulse on every cycle, so it toggles on every cycle; no edge detection is done here.

## Structure
- Shared header `light_timer_defs.vh` holds:
  - state encodings `ST_IDLE`, `ST_RUN`, `ST_PAUSE`, `ST_FULL`;
  - BCD digit limits `BCD_MAX_9` and `BCD_MAX_5`;
  - the 24-bit field bit positions, shared with the display selector.
- One natural sub-module, `bcd_digit_cnt`:
  - parameter `MAX`;
  - inputs `i_clk`, `i_rst_n`, `i_clr`, `i_inc`;
  - outputs `o_digit[3:0]` and `o_carry`, where `o_carry` = `i_inc` & (digit == MAX).
- Instantiate it 6 times in a carry chain.
- The top-level module holds the FSM and the prescaler.

## Test plan
All scenarios use `CLK_DIV` = 4.
1. Reset with buttons idle:
   - Hold `i_rst_n` low for 3 cycles, release → `o_data` = 000000, `o_running` = 0, `o_full` = 0.
2. Basic count:
   - Start pulse, run 40 cycles → `o_data` = 000010. First increment exactly 4 cycles after the start edge.
3. Pause and resume:
   - Start, wait 6 cycles, stop, wait 20 cycles → `o_data` holds 000001.
   - Start again → next increment after 2 more cycles (prescaler value retained).
4. Carry chain:
   - Run to 00:59.99, one more tick → 010000.
   - Run to 09:59.99, one more tick → 100000.
5. Saturation:
   - Run to 59:59.99, one more tick → `o_full` = 1, `o_data` = 595999, `o_running` = 0.
   - Start pulse → no change. Clear pulse → 000000 and IDLE.
6. Simultaneous and mid-operation events:
   - Start and clear in the same cycle while in RUN at 000123 → 000000, IDLE.
   - `i_rst_n` low while in RUN → all outputs at reset values on the next edge.
